// File: rtl/i2c_bus_arbiter_if.sv
// Bus-side bundle for i2c_bus_arbiter: per-requester request/pad enables in,
// one-hot grant, ownership status and the merged pad enables out.
interface i2c_bus_arbiter_if #(
    parameter int unsigned NUM_REQ = 2
);
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ-1:0]         scl_oe_in;
    logic [NUM_REQ-1:0]         sda_oe_in;
    logic [NUM_REQ-1:0]         gnt;
    logic [$clog2(NUM_REQ)-1:0] owner;
    logic                       busy;
    logic                       scl_oe;
    logic                       sda_oe;
    logic                       timeout_err;

    // requester side
    modport master (
        output req, scl_oe_in, sda_oe_in,
        input  gnt, owner, busy, scl_oe, sda_oe, timeout_err
    );

    // arbiter side
    modport slave (
        input  req, scl_oe_in, sda_oe_in,
        output gnt, owner, busy, scl_oe, sda_oe, timeout_err
    );
endinterface

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter granting one I2C requester at a time onto shared SCL/SDA pads,
// with an enforced idle gap between ownerships. Define I2C_ARB_TIMEOUT_EN to bound ownership.
module i2c_bus_arbiter #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned TXN_GAP        = 600,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    i2c_bus_arbiter_if.slave  bus
);
    localparam int unsigned OW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("i2c_bus_arbiter: NUM_REQ or TIMEOUT_CYCLES out of range");
    end

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [OW-1:0]      owner_q, owner_d;
    logic [OW-1:0]      rr_q, rr_d;
    logic [31:0]        cnt_q, cnt_d, cnt_inc;
    logic [NUM_REQ-1:0] eligible;
    logic [OW-1:0]      pick_idx;
    logic               pick_valid;
    logic               timeout_hit;

`ifdef I2C_ARB_TIMEOUT_EN
    logic [NUM_REQ-1:0] mask_q, mask_d;
    logic               terr_q;

    assign timeout_hit = (state_q == GRANT) && (cnt_q == 32'(TIMEOUT_CYCLES - 1));
    assign eligible    = bus.req & ~mask_q;

    // A timed-out requester stays masked until its req is observed low.
    always_comb begin
        mask_d = mask_q & bus.req;
        if (timeout_hit)
            mask_d[owner_q] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q <= '0;
            terr_q <= 1'b0;
        end else begin
            mask_q <= mask_d;
            terr_q <= timeout_hit;
        end
    end

    assign bus.timeout_err = terr_q;
`else
    assign timeout_hit     = 1'b0;
    assign eligible        = bus.req;
    assign bus.timeout_err = 1'b0;
`endif

    // First eligible index strictly after the last owner, wrapping around.
    always_comb begin
        logic [OW-1:0] cand;
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = OW'((32'(rr_q) + i) % NUM_REQ);
            if (!pick_valid && eligible[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        cnt_d   = cnt_inc;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (pick_valid) begin
                    state_d = GRANT;
                    gnt_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                    owner_d = pick_idx;
                    rr_d    = pick_idx;
                end
            end
            GRANT: begin
`ifndef I2C_ARB_TIMEOUT_EN
                cnt_d = '0;
`endif
                if (!bus.req[owner_q] || timeout_hit) begin
                    gnt_d   = '0;
                    cnt_d   = '0;
                    state_d = (TXN_GAP == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (cnt_q == 32'(TXN_GAP - 1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            rr_q    <= OW'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.owner  = owner_q;
    assign bus.busy   = (state_q != IDLE);
    assign bus.scl_oe = (state_q == GRANT) && bus.scl_oe_in[owner_q];
    assign bus.sda_oe = (state_q == GRANT) && bus.sda_oe_in[owner_q];
endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Table-driven bench for i2c_bus_arbiter (NUM_REQ=2, TXN_GAP=4, TIMEOUT_CYCLES=8)
// with expected outputs queued at drive time and compared one edge later.
module tb_i2c_bus_arbiter;
    localparam int unsigned N = 2;

    logic clk = 1'b0;
    logic reset;

    i2c_bus_arbiter_if #(.NUM_REQ(N)) bus ();

    i2c_bus_arbiter #(
        .NUM_REQ        (N),
        .TXN_GAP        (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] gnt;
        logic       owner;
        logic       busy;
        logic       scl;
        logic       sda;
        logic       terr;
    } exp_t;

    typedef struct packed {
        logic [1:0] req;
        logic [1:0] scl_in;
        logic [1:0] sda_in;
        exp_t       e;
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[$];
    int   checks  = 0;
    int   errors  = 0;
    int   step_no = 0;

    function automatic exp_t mk(input logic [1:0] g, input logic o, input logic b,
                                input logic sc, input logic sd, input logic te);
        exp_t e;
        e.gnt = g; e.owner = o; e.busy = b; e.scl = sc; e.sda = sd; e.terr = te;
        return e;
    endfunction

    task automatic add(input logic [1:0] r, input logic [1:0] s, input logic [1:0] d,
                       input logic [1:0] g, input logic o, input logic b,
                       input logic sc, input logic sd);
        vec_t v;
        v.req = r; v.scl_in = s; v.sda_in = d; v.e = mk(g, o, b, sc, sd, 1'b0);
        vecs.push_back(v);
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at step %0d: got %0h expected %0h", name, step_no, act, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expected post-edge outputs, then compare.
    task automatic step(input logic rst, input logic [1:0] r, input logic [1:0] s,
                        input logic [1:0] d, input exp_t e);
        exp_t want;
        @(negedge clk);
        reset         = rst;
        bus.req       = r;
        bus.scl_oe_in = s;
        bus.sda_oe_in = d;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        step_no++;
        cmp("queue", 32'(sbq.size()), 32'd1);
        if (sbq.size() != 0) begin
            want = sbq.pop_front();
            cmp("gnt",         32'(bus.gnt),         32'(want.gnt));
            cmp("owner",       32'(bus.owner),       32'(want.owner));
            cmp("busy",        32'(bus.busy),        32'(want.busy));
            cmp("scl_oe",      32'(bus.scl_oe),      32'(want.scl));
            cmp("sda_oe",      32'(bus.sda_oe),      32'(want.sda));
            cmp("timeout_err", 32'(bus.timeout_err), 32'(want.terr));
        end
    endtask

    task automatic idle_steps(input logic [1:0] r, input int unsigned n,
                              input logic [1:0] g, input logic o, input logic b);
        for (int unsigned i = 0; i < n; i++)
            step(1'b0, r, 2'b00, 2'b00, mk(g, o, b, 1'b0, 1'b0, 1'b0));
    endtask

    initial begin
        reset         = 1'b1;
        bus.req       = '0;
        bus.scl_oe_in = '0;
        bus.sda_oe_in = '0;

        //   req    scl_in sda_in  gnt   own  busy scl sda
        add(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        add(2'b01, 2'b10, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
        add(2'b01, 2'b11, 2'b01, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1);
        add(2'b01, 2'b10, 2'b10, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
        add(2'b11, 2'b01, 2'b01, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1);
        add(2'b10, 2'b11, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        add(2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        add(2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        add(2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        add(2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        add(2'b10, 2'b01, 2'b10, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1);
        add(2'b11, 2'b10, 2'b00, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0);
        add(2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        add(2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        add(2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        add(2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        add(2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        add(2'b01, 2'b00, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
        add(2'b11, 2'b00, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
        add(2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        add(2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        add(2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        add(2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        add(2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        add(2'b11, 2'b00, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
        add(2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        add(2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        add(2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        add(2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        add(2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        add(2'b01, 2'b00, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0);
        add(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        add(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        add(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        add(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        add(2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        add(2'b10, 2'b00, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0);
        add(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        add(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        add(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        add(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        add(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset state
        step(1'b1, 2'b00, 2'b00, 2'b00, mk(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        step(1'b1, 2'b11, 2'b11, 2'b11, mk(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

        foreach (vecs[i])
            step(1'b0, vecs[i].req, vecs[i].scl_in, vecs[i].sda_in, vecs[i].e);

        // Reset mid-grant releases the bus at once; first grant afterwards goes to index 0
        step(1'b0, 2'b10, 2'b00, 2'b10, mk(2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
        step(1'b1, 2'b10, 2'b00, 2'b10, mk(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        step(1'b0, 2'b11, 2'b00, 2'b00, mk(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        idle_steps(2'b00, 4, 2'b00, 1'b0, 1'b1);
        idle_steps(2'b00, 1, 2'b00, 1'b0, 1'b0);

`ifdef I2C_ARB_TIMEOUT_EN
        // Ownership of index 0 expires after 8 grant cycles; index 0 masked until req drops
        step(1'b0, 2'b01, 2'b00, 2'b00, mk(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        idle_steps(2'b11, 7, 2'b01, 1'b0, 1'b1);
        step(1'b0, 2'b11, 2'b00, 2'b00, mk(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
        idle_steps(2'b11, 3, 2'b00, 1'b0, 1'b1);
        idle_steps(2'b11, 1, 2'b00, 1'b0, 1'b0);
        idle_steps(2'b11, 1, 2'b10, 1'b1, 1'b1);
        idle_steps(2'b01, 4, 2'b00, 1'b1, 1'b1);
        idle_steps(2'b01, 4, 2'b00, 1'b1, 1'b0);
        idle_steps(2'b00, 1, 2'b00, 1'b1, 1'b0);
        idle_steps(2'b01, 1, 2'b01, 1'b0, 1'b1);
`else
        // Ownership is unbounded without the timeout feature
        step(1'b0, 2'b01, 2'b00, 2'b00, mk(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        idle_steps(2'b01, 10000, 2'b01, 1'b0, 1'b1);
        idle_steps(2'b00, 4, 2'b00, 1'b0, 1'b1);
        idle_steps(2'b00, 1, 2'b00, 1'b0, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
